if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 151 +++++++++++++++
 tb/tb_if_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, one-outstanding fetch FSM, 2-entry instruction buffer
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   imem_req/addr/ack     fetch request; imem_req & imem_ack is the accepting handshake
//   imem_rvalid/rdata     fetch response, returned at least one cycle after the handshake
//   ir/ir_pc/ir_valid     oldest buffered instruction presented to decode
//   id_ready              decode consumes ir when ir_valid is set
//   redirect/redirect_pc  flush and restart fetch at redirect_pc (low two bits ignored)
`timescale 1ns/1ps
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tag_q, tag_d;

    // Buffer entry 0 is always the oldest; a pop shifts entry 1 down.
    logic [31:0] e0_pc_q, e0_pc_d;
    logic [31:0] e0_ir_q, e0_ir_d;
    logic [31:0] e1_pc_q, e1_pc_d;
    logic [31:0] e1_ir_q, e1_ir_d;
    logic [1:0]  count_q, count_d;

    logic        handshake;
    logic        push;
    logic        pop;
    logic [1:0]  count_after_pop;
    logic        unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    // A request is only raised when the response is guaranteed a free slot,
    // so a push can never overflow the buffer.
    assign imem_req  = ~rst && (state_q == S_IDLE) && !redirect && (count_q != 2'd2);
    assign imem_addr = pc_q;
    assign handshake = imem_req & imem_ack;

    assign ir_valid = (count_q != 2'd0);
    assign ir       = ir_valid ? e0_ir_q : 32'h0000_0000;
    assign ir_pc    = ir_valid ? e0_pc_q : 32'h0000_0000;

    assign push = (state_q == S_WAIT) && imem_rvalid && (count_after_pop != 2'd2);
    assign pop  = ir_valid && id_ready;
    assign count_after_pop = count_q - {1'b0, pop};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tag_d   = tag_q;
        e0_pc_d = e0_pc_q;
        e0_ir_d = e0_ir_q;
        e1_pc_d = e1_pc_q;
        e1_ir_d = e1_ir_q;
        count_d = count_q;

        if (redirect) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            count_d = 2'd0;
            // A response arriving together with the redirect retires the
            // outstanding request; only a still-pending one needs DROP.
            if (imem_rvalid && state_q != S_IDLE) begin
                state_d = S_IDLE;
            end else if (state_q == S_WAIT) begin
                state_d = S_DROP;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (handshake) begin
                        pc_d    = pc_q + 32'd4;
                        tag_d   = pc_q;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = S_IDLE;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (pop) begin
                e0_pc_d = e1_pc_q;
                e0_ir_d = e1_ir_q;
            end
            // The new entry lands right behind whatever survives the pop,
            // which keeps order when push and pop coincide.
            if (push) begin
                if (count_after_pop == 2'd0) begin
                    e0_pc_d = tag_q;
                    e0_ir_d = imem_rdata;
                end else begin
                    e1_pc_d = tag_q;
                    e1_ir_d = imem_rdata;
                end
            end
            count_d = count_after_pop + {1'b0, push};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            tag_q   <= RESET_PC;
            e0_pc_q <= 32'h0;
            e0_ir_q <= 32'h0;
            e1_pc_q <= 32'h0;
            e1_ir_q <= 32'h0;
            count_q <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tag_q   <= tag_d;
            e0_pc_q <= e0_pc_d;
            e0_ir_q <= e0_ir_d;
            e1_pc_q <= e1_pc_d;
            e1_ir_q <= e1_ir_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
`timescale 1ns/1ps
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int tests;
    int fails;

    logic        auto_mem;
    logic        amem_hs;
    logic [31:0] amem_a;

    if_stage dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
        .id_ready(id_ready), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Auto responder: every handshake seen at a negedge gets rvalid in the next cycle.
    always begin
        @(negedge clk);
        amem_hs = auto_mem & imem_req & imem_ack;
        amem_a  = imem_addr;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            imem_rvalid = amem_hs;
            imem_rdata  = amem_hs ? mem_word(amem_a) : 32'h0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
    endtask

    task automatic do_reset;
        auto_mem = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        imem_ack = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        id_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        at_neg();
        tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL reset_ir_valid got %0b want 0", ir_valid); end
        tests++; if (ir !== 32'h0) begin fails++; $display("FAIL reset_ir got %08h want 0", ir); end
        tests++; if (ir_pc !== 32'h0) begin fails++; $display("FAIL reset_ir_pc got %08h want 0", ir_pc); end
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_imem_req got %0b want 0", imem_req); end
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_imem_addr got %08h want 0", imem_addr); end
    endtask

    task automatic test_stream;
        logic        e_req, e_val;
        logic [31:0] e_pc;
        do_reset();
        auto_mem = 1'b1; imem_ack = 1'b1; id_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            at_neg();
            e_req = (i % 2 == 0);
            e_val = (i >= 2) && (i % 2 == 0);
            tests++; if (imem_req !== e_req) begin fails++; $display("FAIL stream_req[%0d] got %0b want %0b", i, imem_req, e_req); end
            if (e_req) begin
                tests++; if (imem_addr !== 32'(4 * (i / 2))) begin fails++; $display("FAIL stream_addr[%0d] got %08h want %08h", i, imem_addr, 32'(4 * (i / 2))); end
            end
            tests++; if (ir_valid !== e_val) begin fails++; $display("FAIL stream_valid[%0d] got %0b want %0b", i, ir_valid, e_val); end
            if (e_val) begin
                e_pc = 32'(4 * (i / 2 - 1));
                tests++; if (ir_pc !== e_pc) begin fails++; $display("FAIL stream_ir_pc[%0d] got %08h want %08h", i, ir_pc, e_pc); end
                tests++; if (ir !== mem_word(e_pc)) begin fails++; $display("FAIL stream_ir[%0d] got %08h want %08h", i, ir, mem_word(e_pc)); end
            end
        end
    endtask

    task automatic test_stall;
        do_reset();
        auto_mem = 1'b1; imem_ack = 1'b1; id_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            at_neg();
            if (i >= 2) begin
                tests++; if (ir_pc !== 32'h0) begin fails++; $display("FAIL stall_stable_pc[%0d] got %08h want 0", i, ir_pc); end
            end
        end
        tests++; if (ir_valid !== 1'b1) begin fails++; $display("FAIL stall_valid got %0b want 1", ir_valid); end
        tests++; if (ir !== mem_word(32'h0)) begin fails++; $display("FAIL stall_ir got %08h want %08h", ir, mem_word(32'h0)); end
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stall_req got %0b want 0", imem_req); end
        tick(); id_ready = 1'b1;
        at_neg();
        tests++; if (ir_pc !== 32'h0) begin fails++; $display("FAIL stall_rel0_pc got %08h want 0", ir_pc); end
        tick();
        at_neg();
        tests++; if (ir_pc !== 32'h4) begin fails++; $display("FAIL stall_rel1_pc got %08h want 4", ir_pc); end
        tests++; if (ir !== mem_word(32'h4)) begin fails++; $display("FAIL stall_rel1_ir got %08h want %08h", ir, mem_word(32'h4)); end
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL stall_resume_req got %0b want 1", imem_req); end
        tests++; if (imem_addr !== 32'h8) begin fails++; $display("FAIL stall_resume_addr got %08h want 8", imem_addr); end
        tick();
        at_neg();
        tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL stall_drained got %0b want 0", ir_valid); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        imem_ack = 1'b1; id_ready = 1'b0;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0000;
        tick();
        imem_rvalid = 1'b0;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hBBBB_0004; id_ready = 1'b1;
        at_neg();
        tests++; if (ir !== 32'hAAAA_0000) begin fails++; $display("FAIL b2b_first_ir got %08h want AAAA0000", ir); end
        tick();
        imem_rvalid = 1'b0;
        at_neg();
        tests++; if (ir_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid got %0b want 1", ir_valid); end
        tests++; if (ir_pc !== 32'h4) begin fails++; $display("FAIL b2b_ir_pc got %08h want 4", ir_pc); end
        tests++; if (ir !== 32'hBBBB_0004) begin fails++; $display("FAIL b2b_ir got %08h want BBBB0004", ir); end
        tests++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin fails++; $display("FAIL b2b_next_req got req=%0b addr=%08h want req=1 addr=8", imem_req, imem_addr); end
        tick();
        at_neg();
        tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL b2b_drained got %0b want 0", ir_valid); end
    endtask

    task automatic test_redirect_wait;
        do_reset();
        imem_ack = 1'b1; id_ready = 1'b0;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_0000;
        tick();
        imem_rvalid = 1'b0;
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        at_neg();
        tests++; if (ir_valid !== 1'b1) begin fails++; $display("FAIL rdw_pre_valid got %0b want 1", ir_valid); end
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rdw_req_during got %0b want 0", imem_req); end
        tick();
        redirect = 1'b0;
        at_neg();
        tests++; if (ir_valid !== 1'b0 || ir !== 32'h0 || ir_pc !== 32'h0) begin fails++; $display("FAIL rdw_flushed got valid=%0b ir=%08h pc=%08h want 0/0/0", ir_valid, ir, ir_pc); end
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rdw_drop_req got %0b want 0", imem_req); end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        at_neg();
        tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL rdw_discard got %0b want 0", ir_valid); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin fails++; $display("FAIL rdw_next_fetch got req=%0b addr=%08h want req=1 addr=00000100", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_rvalid;
        do_reset();
        imem_ack = 1'b1; id_ready = 1'b1;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD1_BAD1; redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        imem_rvalid = 1'b0; redirect = 1'b0;
        at_neg();
        tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL rdr_dropped got %0b want 0", ir_valid); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin fails++; $display("FAIL rdr_next_fetch got req=%0b addr=%08h want req=1 addr=00000100", imem_req, imem_addr); end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h2222_0100; id_ready = 1'b0;
        tick();
        imem_rvalid = 1'b0;
        at_neg();
        tests++; if (ir_pc !== 32'h100 || ir !== 32'h2222_0100) begin fails++; $display("FAIL rdr_new_instr got pc=%08h ir=%08h want 00000100/22220100", ir_pc, ir); end
    endtask

    task automatic test_wrap;
        do_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0; imem_ack = 1'b1; id_ready = 1'b0;
        at_neg();
        tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL wrap_post_redirect_valid got %0b want 0", ir_valid); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_first got req=%0b addr=%08h want req=1 addr=FFFFFFFC", imem_req, imem_addr); end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h3333_FFFC;
        tick();
        imem_rvalid = 1'b0;
        at_neg();
        tests++; if (ir_pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_ir_pc got %08h want FFFFFFFC", ir_pc); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_second got req=%0b addr=%08h want req=1 addr=00000000", imem_req, imem_addr); end
    endtask

    task automatic test_reset_mid_wait;
        do_reset();
        imem_ack = 1'b1; id_ready = 1'b0;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h4444_0000;
        tick();
        imem_rvalid = 1'b0;
        tick();
        tests++; if (ir_valid !== 1'b1) begin fails++; $display("FAIL rmw_pre_valid got %0b want 1", ir_valid); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (ir_valid !== 1'b0 || ir !== 32'h0 || ir_pc !== 32'h0) begin fails++; $display("FAIL rmw_async_out got valid=%0b ir=%08h pc=%08h want 0/0/0", ir_valid, ir, ir_pc); end
        tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin fails++; $display("FAIL rmw_async_req got req=%0b addr=%08h want 0/0", imem_req, imem_addr); end
        imem_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD2_BAD2;
        at_neg();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL rmw_first_req got req=%0b addr=%08h want 1/0", imem_req, imem_addr); end
        tick();
        imem_rvalid = 1'b0;
        at_neg();
        tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL rmw_stray_ignored got %0b want 0", ir_valid); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL rmw_still_idle got req=%0b addr=%08h want 1/0", imem_req, imem_addr); end
    endtask

    initial begin
        tests = 0; fails = 0;
        auto_mem = 1'b0;
        rst = 1'b1;
        imem_ack = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        id_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_back_to_back();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
